// File: rtl/sram_sync_if.sv
// Request/response bundle for sram_sync_param.
//   master : drives req_valid/write_en/address/data_in/byte_en (and par_inject)
//   slave  : drives req_ready/data_out/rd_valid/init_busy (and parity_err)
// Optional macro SRAM_SYNC_PARITY_EN adds par_inject and parity_err.
interface sram_sync_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  write_en;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W-1:0]     data_in;
    logic [DATA_W/8-1:0]   byte_en;
    logic [DATA_W-1:0]     data_out;
    logic                  rd_valid;
    logic                  init_busy;
`ifdef SRAM_SYNC_PARITY_EN
    logic                  par_inject;
    logic                  parity_err;
`endif

    modport master (
`ifdef SRAM_SYNC_PARITY_EN
        output par_inject,
        input  parity_err,
`endif
        output req_valid, write_en, address, data_in, byte_en,
        input  req_ready, data_out, rd_valid, init_busy
    );

    modport slave (
`ifdef SRAM_SYNC_PARITY_EN
        input  par_inject,
        output parity_err,
`endif
        input  req_valid, write_en, address, data_in, byte_en,
        output req_ready, data_out, rd_valid, init_busy
    );
endinterface

// File: rtl/sram_sync_param.sv
// Synchronous single-port SRAM with byte enables, power-on clear and
// selectable read latency.
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : sram_sync_if.slave (request in, read data / status out)
// Parameters: DATA_W (multiple of 8), ADDR_W (DEPTH = 2**ADDR_W),
//             OUT_REG (0 = data one edge after accept, 1 = two edges).
// Optional macro SRAM_SYNC_PARITY_EN: one even-parity bit per stored byte,
// par_inject forces bad parity on write, parity_err flags it on read.

// One byte lane of storage: memory array plus a resettable read register.
module sram_sync_lane #(
    parameter int ADDR_W = 4,
    parameter int LANE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [LANE_W-1:0] wdata,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] raddr,
    output logic [LANE_W-1:0] rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [LANE_W-1:0] mem [DEPTH];

    // Storage has no reset; the INIT sweep clears it instead.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Holds the last read word so data_out is stable between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rdata <= '0;
        else if (rd_en) rdata <= mem[raddr];
    end
endmodule

module sram_sync_param #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int OUT_REG = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    sram_sync_if.slave bus
);
    localparam int NUM_LANES = DATA_W / 8;
    localparam int DEPTH     = 1 << ADDR_W;
    localparam int STAGES    = (OUT_REG != 0) ? 2 : 1;
`ifdef SRAM_SYNC_PARITY_EN
    localparam int LANE_W = 9;
`else
    localparam int LANE_W = 8;
`endif

    typedef enum logic {ST_INIT, ST_IDLE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] init_addr_q, init_addr_d;
    logic              in_init, ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        in_init     = 1'b0;
        ready       = 1'b0;
        case (state_q)
            ST_INIT: begin
                in_init     = 1'b1;
                init_addr_d = init_addr_q + 1'b1;
                if (init_addr_q == ADDR_W'(DEPTH - 1)) state_d = ST_IDLE;
            end
            ST_IDLE: ready = 1'b1;
            default: state_d = ST_INIT;
        endcase
    end

    assign bus.init_busy = in_init;
    assign bus.req_ready = ready;

    logic accept, rd_acc, wr_acc;
    assign accept = bus.req_valid & ready;
    assign rd_acc = accept & ~bus.write_en;
    assign wr_acc = accept &  bus.write_en;

    logic [ADDR_W-1:0]                  lane_waddr;
    logic [NUM_LANES-1:0]               lane_we;
    logic [NUM_LANES-1:0][LANE_W-1:0]   lane_wdata;
    logic [NUM_LANES-1:0][LANE_W-1:0]   lane_rdata;
    logic [NUM_LANES-1:0]               lane_perr;
    logic [DATA_W-1:0]                  rd_word;

    assign lane_waddr = in_init ? init_addr_q : bus.address;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [7:0] wbyte;
        assign wbyte      = bus.data_in[8*i +: 8];
        assign lane_we[i] = in_init | (wr_acc & bus.byte_en[i]);
`ifdef SRAM_SYNC_PARITY_EN
        // Even parity bit; par_inject stores the complement to fake a fault.
        assign lane_wdata[i] = in_init ? '0 : {(^wbyte) ^ bus.par_inject, wbyte};
        assign lane_perr[i]  = lane_rdata[i][8] ^ (^lane_rdata[i][7:0]);
`else
        assign lane_wdata[i] = in_init ? '0 : wbyte;
        assign lane_perr[i]  = 1'b0;
`endif
        assign rd_word[8*i +: 8] = lane_rdata[i][7:0];

        sram_sync_lane #(.ADDR_W(ADDR_W), .LANE_W(LANE_W)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (lane_we[i]),
            .waddr (lane_waddr),
            .wdata (lane_wdata[i]),
            .rd_en (rd_acc),
            .raddr (bus.address),
            .rdata (lane_rdata[i])
        );
    end

    // Read valid shift register; stage 1 coincides with the lane read register.
    logic [STAGES:1] vld_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= rd_acc;
            for (int s = 2; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
        end
    end

    assign bus.rd_valid = vld_pipe[STAGES];

    logic perr_word;
    assign perr_word = |lane_perr;

    if (OUT_REG != 0) begin : g_oreg
        logic [DATA_W-1:0] dout_q;
        logic              perr_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_q <= '0;
                perr_q <= 1'b0;
            end else if (vld_pipe[1]) begin
                dout_q <= rd_word;
                perr_q <= perr_word;
            end
        end
        assign bus.data_out = dout_q;
`ifdef SRAM_SYNC_PARITY_EN
        assign bus.parity_err = vld_pipe[STAGES] & perr_q;
`endif
    end else begin : g_noreg
        assign bus.data_out = rd_word;
`ifdef SRAM_SYNC_PARITY_EN
        assign bus.parity_err = vld_pipe[STAGES] & perr_word;
`endif
    end
endmodule

// File: tb/tb_sram_sync_param.sv
// Bench for sram_sync_param: two DUTs (DATA_W=32, OUT_REG=0 and 1) share
// stimulus; a word/byte-level memory model predicts every output each cycle.
module tb_sram_sync_param;
    localparam int DW = 32, AW = 4, DEPTH = 16, NB = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sram_sync_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
    sram_sync_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

    sram_sync_param #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    sram_sync_param #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Current stimulus
    logic          r_valid, r_we, r_inj;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_din;
    logic [NB-1:0] r_be;

    // Reference model
    logic [DW-1:0] ref_mem [DEPTH];
    logic [NB-1:0] ref_bad [DEPTH];
    int            init_rem;
    logic          e0_v, e1_v, e0_p, e1_p;
    logic [DW-1:0] e0_d, e1_d;

    task automatic drive(input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [NB-1:0] be, input logic inj);
        r_valid = v; r_we = we; r_addr = a; r_din = d; r_be = be;
`ifdef SRAM_SYNC_PARITY_EN
        r_inj = inj;
        bus0.par_inject = inj; bus1.par_inject = inj;
`else
        r_inj = 1'b0 & inj;
`endif
        bus0.req_valid = v; bus0.write_en = we; bus0.address = a; bus0.data_in = d; bus0.byte_en = be;
        bus1.req_valid = v; bus1.write_en = we; bus1.address = a; bus1.data_in = d; bus1.byte_en = be;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic model_reset();
        e0_v = 0; e1_v = 0; e0_p = 0; e1_p = 0; e0_d = '0; e1_d = '0;
        init_rem = DEPTH;
    endtask

    task automatic model_edge();
        logic acc;
        acc = (init_rem == 0) && r_valid;
        // OUT_REG=1 shows what OUT_REG=0 showed one edge earlier
        e1_v = e0_v;
        if (e0_v) begin e1_d = e0_d; e1_p = e0_p; end
        if (init_rem > 0) begin
            ref_mem[DEPTH - init_rem] = '0;
            ref_bad[DEPTH - init_rem] = '0;
            init_rem--;
            e0_v = 0;
        end else begin
            e0_v = acc && !r_we;
            if (e0_v) begin
                e0_d = ref_mem[r_addr];
                e0_p = |ref_bad[r_addr];
            end
            if (acc && r_we)
                for (int i = 0; i < NB; i++)
                    if (r_be[i]) begin
                        ref_mem[r_addr][8*i +: 8] = r_din[8*i +: 8];
                        ref_bad[r_addr][i] = r_inj;
                    end
        end
    endtask

    task automatic check_outputs();
        chk("init_busy0", bus0.init_busy, init_rem > 0);
        chk("req_ready0", bus0.req_ready, init_rem == 0);
        chk("init_busy1", bus1.init_busy, init_rem > 0);
        chk("req_ready1", bus1.req_ready, init_rem == 0);
        chk("rd_valid0", bus0.rd_valid, e0_v);
        chk("data_out0", bus0.data_out, e0_d);
        chk("rd_valid1", bus1.rd_valid, e1_v);
        chk("data_out1", bus1.data_out, e1_d);
`ifdef SRAM_SYNC_PARITY_EN
        chk("parity_err0", bus0.parity_err, e0_v & e0_p);
        chk("parity_err1", bus1.parity_err, e1_v & e1_p);
`endif
    endtask

    // One clock: model follows the edge, outputs sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic rand_req();
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, AW'($urandom_range(0, DEPTH-1)),
              DW'($urandom), NB'($urandom_range(0, 15)), $urandom_range(0, 7) == 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int busy_cnt;
        logic [DW-1:0] d;
        rst_n = 1'b0;
        model_reset();
        rand_req();
        repeat (3) step();

        // Release and measure INIT length while random requests are ignored
        rst_n = 1'b1;
        busy_cnt = 0;
        for (int k = 0; k < 40 && bus0.init_busy; k++) begin
            rand_req();
            step();
            busy_cnt++;
        end
        chk("init_cycles", busy_cnt, DEPTH);
        idle();

        // All addresses cleared
        for (int a = 0; a < DEPTH; a++) begin drive(1, 0, AW'(a), '0, '0, 0); step(); end
        idle(); repeat (2) step();

        // Write then immediate read of the same address
        for (int a = 0; a < DEPTH; a++) begin
            drive(1, 1, AW'(a), DW'($urandom), '1, 0); step();
            drive(1, 0, AW'(a), '0, '0, 0); step();
        end
        idle(); repeat (2) step();

        // Back-to-back reads
        for (int a = DEPTH-1; a >= 0; a--) begin drive(1, 0, AW'(a), '0, '0, 0); step(); end
        idle(); repeat (2) step();

        // Byte-enable merge and byte_en = 0 no-op
        drive(1, 1, 4'd5, 32'h11223344, 4'b1111, 0); step();
        drive(1, 1, 4'd5, 32'hAABBCCDD, 4'b0101, 0); step();
        drive(1, 0, 4'd5, '0, '0, 0); step();
        idle();
        chk("be_merge0", bus0.data_out, 32'h11BB33DD);
        step();
        chk("be_merge1", bus1.data_out, 32'h11BB33DD);
        drive(1, 1, 4'd5, 32'hFFFFFFFF, 4'b0000, 0); step();
        drive(1, 0, 4'd5, '0, '0, 0); step();
        idle();
        chk("be_noop0", bus0.data_out, 32'h11BB33DD);
        step();

        // Random traffic
        for (int k = 0; k < 400; k++) begin rand_req(); step(); end
        idle(); repeat (2) step();

`ifdef SRAM_SYNC_PARITY_EN
        drive(1, 1, 4'd3, 32'h5A, '1, 1); step();
        drive(1, 0, 4'd3, '0, '0, 0); step();
        idle();
        chk("perr_inj_v0", {bus0.rd_valid, bus0.parity_err}, 2'b11);
        chk("perr_inj_d0", bus0.data_out, 32'h5A);
        step();
        chk("perr_inj_v1", {bus1.rd_valid, bus1.parity_err}, 2'b11);
        drive(1, 1, 4'd4, 32'h5A, '1, 0); step();
        drive(1, 0, 4'd4, '0, '0, 0); step();
        idle();
        chk("perr_ok0", {bus0.rd_valid, bus0.parity_err}, 2'b10);
        repeat (2) step();
`endif

        // Reset while a read is in flight
        d = DW'($urandom) | 32'h1;
        drive(1, 1, 4'd7, d, '1, 0); step();
        drive(1, 0, 4'd7, '0, '0, 0); step();
        idle();
        chk("pre_rst_d0", bus0.data_out, d);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_rv0", bus0.rd_valid, 0);
        chk("rst_do0", bus0.data_out, 0);
        chk("rst_rv1", bus1.rd_valid, 0);
        chk("rst_do1", bus1.data_out, 0);
        chk("rst_busy", bus0.init_busy, 1);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (DEPTH) step();
        drive(1, 0, 4'd7, '0, '0, 0); step();
        idle();
        chk("rezero7", bus0.data_out, 0);
        for (int a = 0; a < DEPTH; a++) begin drive(1, 0, AW'(a), '0, '0, 0); step(); end
        idle(); repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_sync_param.md
SRAM_SYNC_PARAM -- requirements
Module: sram_sync_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, data width in bits (multiple of 8, 8..64).
REQ-002 The block SHALL have parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W words.
REQ-003 The block SHALL have parameter OUT_REG, default 0, read latency select (0 = 1 cycle, 1 = 2 cycles).
REQ-004 The block SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port req_valid, input, 1, request present.
REQ-007 The block SHALL have port req_ready, output, 1, block can accept a request.
REQ-008 The block SHALL have port write_en, input, 1, 1 = write request, 0 = read request.
REQ-009 The block SHALL have port address, input, ADDR_W, word address.
REQ-010 The block SHALL have port data_in, input, DATA_W, write data.
REQ-011 The block SHALL have port byte_en, input, DATA_W/8, per-byte write enable (bit i covers data_in[8i+7:8i]).
REQ-012 The block SHALL have port data_out, output, DATA_W, read data.
REQ-013 The block SHALL have port rd_valid, output, 1, one-cycle pulse marking valid data_out.
REQ-014 The block SHALL have port init_busy, output, 1, memory clear in progress.

Function
REQ-015 The FSM SHALL have two states: INIT (clear memory) and IDLE (serve requests).
REQ-016 In INIT, the block SHALL write zero to addresses 0..DEPTH-1, one per cycle, ascending, then enter IDLE; INIT SHALL last exactly DEPTH cycles.
REQ-017 init_busy SHALL be 1 and req_ready 0 in INIT; init_busy SHALL be 0 and req_ready 1 in IDLE.
REQ-018 A request SHALL be accepted on a rising edge where req_valid && req_ready; req_valid in INIT SHALL be ignored and not queued.
REQ-019 An accepted write SHALL update only the bytes whose byte_en bit is 1, leaving the others unchanged; byte_en = 0 SHALL be accepted as a no-op.
REQ-020 An accepted write SHALL NOT pulse rd_valid or change data_out.
REQ-021 An accepted read SHALL drive data_out and pulse rd_valid for one cycle 1 edge after acceptance (OUT_REG=0) or 2 edges after (OUT_REG=1).
REQ-022 Back-to-back reads SHALL be accepted every cycle, yielding rd_valid on consecutive cycles in request order.
REQ-023 A read accepted the cycle after a write to the same address SHALL return the newly written data.
REQ-024 data_out SHALL hold the last read value until the next read completes.
REQ-025 Every address 0..DEPTH-1 SHALL be valid; there is no out-of-range case.

Reset
REQ-026 On rst_n low, the block SHALL immediately force the FSM to INIT, init_busy=1, req_ready=0, rd_valid=0, data_out=0, and clear the read pipeline.
REQ-027 Reads in flight when reset asserts SHALL be discarded and produce no rd_valid.
REQ-028 After rst_n deasserts, INIT SHALL start from address 0 on the first rising edge, re-zeroing all contents.

Configuration
REQ-029 Macro SRAM_SYNC_PARITY_EN SHALL add one even-parity bit per stored byte, plus an input par_inject (1) and an output parity_err (1).
REQ-030 With SRAM_SYNC_PARITY_EN defined, an accepted write with par_inject=1 SHALL store inverted parity for the enabled bytes, and a read whose recomputed parity mismatches in any byte SHALL pulse parity_err with its rd_valid; parity_err SHALL reset to 0.
REQ-031 Without SRAM_SYNC_PARITY_EN, the parity bits, par_inject and parity_err SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-032 The bench SHALL release reset and check that init_busy=1 for exactly 16 cycles (ADDR_W=4), then read all 16 addresses, each returning 0x00.
REQ-033 The bench SHALL write random data to addresses 0..15 and read each back immediately, checking data_out against the written value with rd_valid at latency 1 (OUT_REG=0) and latency 2 (OUT_REG=1).
REQ-034 With DATA_W=32, the bench SHALL write 0x11223344 to address 5, then write 0xAABBCCDD with byte_en=4'b0101, and check that a read returns 0x11BB33DD.
REQ-035 The bench SHALL assert rst_n low while a read is in flight, check rd_valid=0 and data_out=0 immediately, then check that the INIT re-zeroes previously written addresses.
REQ-036 With SRAM_SYNC_PARITY_EN defined, the bench SHALL write 0x5A with par_inject=1 to address 3 and check that a read returns 0x5A with parity_err=1 coincident with rd_valid; a normal write followed by a read SHALL give parity_err=0.
